pipe_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. It turns hazard and wait indications from the fetch, decode, execute and memory stages into per-register hold and flush (bubble) controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also emits the 4-bit stall-cause vector the pipeline registers consume. It owns the multi-cycle execute countdown and the wrong-path fetch discard that must survive an instruction-memory wait.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipe_ctrl_if.sv | 30 +++
 rtl/pipe_ctrl_perf.sv | 29 ++
 rtl/pipe_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_ctrl.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: cause bits,
// pipeline register indices and FSM state encoding.
package pipe_ctrl_pkg;

   localparam int unsigned STALL_INST = 0;
   localparam int unsigned STALL_ID   = 1;
   localparam int unsigned STALL_EXE  = 2;
   localparam int unsigned STALL_DATA = 3;

   localparam int unsigned IF_ID  = 0;
   localparam int unsigned ID_EX  = 1;
   localparam int unsigned EX_MEM = 2;
   localparam int unsigned MEM_WB = 3;

   localparam logic [0:0] ST_RUN = 1'b0;
   localparam logic [0:0] ST_MC  = 1'b1;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs, hold/flush/stall controls and perf counters between the
// pipeline stages (master) and the controller (slave).
interface pipe_ctrl_if;

   logic        imem_wait;
   logic        dmem_wait;
   logic        id_load_use;
   logic        ex_mc_start;
   logic [4:0]  ex_mc_cycles;
   logic        id_branch_taken;
   logic        pc_en;
   logic [3:0]  hold;
   logic [3:0]  flush;
   logic [3:0]  stall;
   logic [31:0] perf_inst;
   logic [31:0] perf_id;
   logic [31:0] perf_exe;
   logic [31:0] perf_data;

   modport master (
      output imem_wait, dmem_wait, id_load_use, ex_mc_start, ex_mc_cycles, id_branch_taken,
      input  pc_en, hold, flush, stall, perf_inst, perf_id, perf_exe, perf_data
   );

   modport slave (
      input  imem_wait, dmem_wait, id_load_use, ex_mc_start, ex_mc_cycles, id_branch_taken,
      output pc_en, hold, flush, stall, perf_inst, perf_id, perf_exe, perf_data
   );

endinterface

// File: rtl/pipe_ctrl_perf.sv
// Four 32-bit saturating stall-cycle counters, one per acting cause.
module pipe_ctrl_perf (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  act_i,
   output logic [31:0] perf_inst_o,
   output logic [31:0] perf_id_o,
   output logic [31:0] perf_exe_o,
   output logic [31:0] perf_data_o
);
   import pipe_ctrl_pkg::*;

   logic [31:0] cnt_q [4];

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < 4; i++) begin
         if (rst)
            cnt_q[i] <= '0;
         else if (act_i[i] && cnt_q[i] != '1)
            cnt_q[i] <= cnt_q[i] + 32'd1;
      end
   end

   assign perf_inst_o = cnt_q[STALL_INST];
   assign perf_id_o   = cnt_q[STALL_ID];
   assign perf_exe_o  = cnt_q[STALL_EXE];
   assign perf_data_o = cnt_q[STALL_DATA];

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: oldest-stage-wins hazard arbitration,
// multi-cycle EX countdown and wrong-path fetch discard. PIPE_CTRL_PERF_EN builds perf counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input logic       clk,
   input logic       rst,
   pipe_ctrl_if.slave bus
);

   logic [0:0] state_q, state_d;
   logic [4:0] mc_q, mc_d;
   logic       pend_q, pend_d;
   logic       c_data, c_exe, c_id, c_inst, upper;
   logic       br_act, pend_fire;
   logic [3:0] cause;

   always_comb begin
      c_data    = bus.dmem_wait;
      c_exe     = !c_data && (state_q == ST_MC || (bus.ex_mc_start && bus.ex_mc_cycles != '0));
      c_id      = !c_data && !c_exe && bus.id_load_use;
      upper     = c_data || c_exe || c_id;
      c_inst    = !upper && bus.imem_wait;
      br_act    = bus.id_branch_taken && !upper;
      // A discard owed across an imem wait fires only once if_id is free to take a bubble.
      pend_fire = pend_q && !upper && !bus.imem_wait;
      cause     = '0;
      cause[STALL_DATA] = c_data;
      cause[STALL_EXE]  = c_exe;
      cause[STALL_ID]   = c_id;
      cause[STALL_INST] = c_inst;
   end

   always_comb begin
      bus.pc_en = !(upper || c_inst);
      bus.stall = cause;
      bus.hold  = '0;
      bus.flush = '0;
      bus.hold[IF_ID]   = upper;
      bus.hold[ID_EX]   = c_data || c_exe;
      bus.hold[EX_MEM]  = c_data;
      bus.flush[MEM_WB] = c_data;
      bus.flush[EX_MEM] = c_exe;
      bus.flush[ID_EX]  = c_id;
      bus.flush[IF_ID]  = c_inst || br_act || pend_fire;
      if (rst) begin
         bus.pc_en = 1'b0;
         bus.stall = '0;
         bus.hold  = '0;
         bus.flush = '1;
      end
   end

   always_comb begin
      state_d = state_q;
      mc_d    = mc_q;
      pend_d  = pend_q ? (bus.imem_wait || upper) : (br_act && bus.imem_wait);
      case (state_q)
         ST_RUN: begin
            if (!c_data && bus.ex_mc_start && bus.ex_mc_cycles >= 5'd2) begin
               state_d = ST_MC;
               mc_d    = bus.ex_mc_cycles - 5'd1;
            end
         end
         ST_MC: begin
            if (!bus.dmem_wait) begin
               if (mc_q == 5'd1) begin
                  state_d = ST_RUN;
                  mc_d    = '0;
               end else begin
                  mc_d = mc_q - 5'd1;
               end
            end
         end
         default: begin
            state_d = ST_RUN;
            mc_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         mc_q    <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mc_q    <= mc_d;
         pend_q  <= pend_d;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] p_inst, p_id, p_exe, p_data;

   pipe_ctrl_perf u_perf (
      .clk         (clk),
      .rst         (rst),
      .act_i       (cause),
      .perf_inst_o (p_inst),
      .perf_id_o   (p_id),
      .perf_exe_o  (p_exe),
      .perf_data_o (p_data)
   );

   assign bus.perf_inst = p_inst;
   assign bus.perf_id   = p_id;
   assign bus.perf_exe  = p_exe;
   assign bus.perf_data = p_data;
`else
   assign bus.perf_inst = '0;
   assign bus.perf_id   = '0;
   assign bus.perf_exe  = '0;
   assign bus.perf_data = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl with hand-computed expected controls.
module tb_pipe_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;

   pipe_ctrl_if bus ();

   pipe_ctrl u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic pc, input logic [3:0] h,
                             input logic [3:0] f, input logic [3:0] s);
      check({tag, ".pc_en"}, {31'd0, bus.pc_en}, {31'd0, pc});
      check({tag, ".hold"},  {28'd0, bus.hold},  {28'd0, h});
      check({tag, ".flush"}, {28'd0, bus.flush}, {28'd0, f});
      check({tag, ".stall"}, {28'd0, bus.stall}, {28'd0, s});
   endtask

   // Apply one cycle of inputs just after the edge; outputs are sampled 2 ns later.
   task automatic step(input logic r, input logic im, input logic dm, input logic lu,
                       input logic mcs, input logic [4:0] k, input logic br);
      @(posedge clk);
      #1;
      rst                 = r;
      bus.imem_wait       = im;
      bus.dmem_wait       = dm;
      bus.id_load_use     = lu;
      bus.ex_mc_start     = mcs;
      bus.ex_mc_cycles    = k;
      bus.id_branch_taken = br;
      #2;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      bus.imem_wait = 1'b0; bus.dmem_wait = 1'b0; bus.id_load_use = 1'b0;
      bus.ex_mc_start = 1'b0; bus.ex_mc_cycles = 5'd0; bus.id_branch_taken = 1'b0;

      // reset
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1);
      expect_out("rst", 1'b0, 4'b0000, 4'b1111, 4'b0000);
      check("rst.state", {31'd0, u_dut.state_q}, 32'd0);
      check("rst.mc",    {27'd0, u_dut.mc_q},    32'd0);
      check("rst.pend",  {31'd0, u_dut.pend_q},  32'd0);
      idle();
      expect_out("idle", 1'b1, 4'b0000, 4'b0000, 4'b0000);

      // imem wait x3
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
         expect_out("imem", 1'b0, 4'b0000, 4'b0001, 4'b0001);
      end
      idle();
      expect_out("imem.rel", 1'b1, 4'b0000, 4'b0000, 4'b0000);
`ifdef PIPE_CTRL_PERF_EN
      check("perf_inst", bus.perf_inst, 32'd3);
`else
      check("perf_inst", bus.perf_inst, 32'd0);
`endif

      // K=4, no interference
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0);
      expect_out("mc4.c0", 1'b0, 4'b0011, 4'b0100, 4'b0100);
      for (int i = 1; i < 4; i++) begin
         idle();
         if (i == 1) begin
            check("mc4.state", {31'd0, u_dut.state_q}, 32'd1);
            check("mc4.cnt",   {27'd0, u_dut.mc_q},    32'd3);
         end
         expect_out("mc4.cn", 1'b0, 4'b0011, 4'b0100, 4'b0100);
      end
      idle();
      expect_out("mc4.end", 1'b1, 4'b0000, 4'b0000, 4'b0000);
      check("mc4.run", {31'd0, u_dut.state_q}, 32'd0);

      // K=0 and K=1
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
      expect_out("k0", 1'b1, 4'b0000, 4'b0000, 4'b0000);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0);
      expect_out("k1", 1'b0, 4'b0011, 4'b0100, 4'b0100);
      idle();
      expect_out("k1.end", 1'b1, 4'b0000, 4'b0000, 4'b0000);
      check("k1.state", {31'd0, u_dut.state_q}, 32'd0);

      // K=4 with two dmem_wait cycles inside MC: 6 stall cycles
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0);
      expect_out("mcd.c0", 1'b0, 4'b0011, 4'b0100, 4'b0100);
      idle();
      expect_out("mcd.c1", 1'b0, 4'b0011, 4'b0100, 4'b0100);
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
         expect_out("mcd.data", 1'b0, 4'b0111, 4'b1000, 4'b1000);
      end
      check("mcd.frozen", {27'd0, u_dut.mc_q}, 32'd2);
      idle();
      expect_out("mcd.c4", 1'b0, 4'b0011, 4'b0100, 4'b0100);
      idle();
      expect_out("mcd.c5", 1'b0, 4'b0011, 4'b0100, 4'b0100);
      idle();
      expect_out("mcd.end", 1'b1, 4'b0000, 4'b0000, 4'b0000);

      // branch across imem wait
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
      expect_out("br.w0", 1'b0, 4'b0000, 4'b0001, 4'b0001);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      check("br.pend", {31'd0, u_dut.pend_q}, 32'd1);
      expect_out("br.w1", 1'b0, 4'b0000, 4'b0001, 4'b0001);
      idle();
      expect_out("br.fire", 1'b1, 4'b0000, 4'b0001, 4'b0000);
      idle();
      check("br.pclr", {31'd0, u_dut.pend_q}, 32'd0);
      expect_out("br.done", 1'b1, 4'b0000, 4'b0000, 4'b0000);

      // plain branch, and branch masked by load-use
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
      expect_out("br.plain", 1'b1, 4'b0000, 4'b0001, 4'b0000);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
      expect_out("br.lu", 1'b0, 4'b0001, 4'b0010, 4'b0010);

      // load-use beats imem wait
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
      expect_out("lu.im", 1'b0, 4'b0001, 4'b0010, 4'b0010);

      // dmem_wait with ex_mc_start: start is lost
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0);
      expect_out("dm.mcs", 1'b0, 4'b0111, 4'b1000, 4'b1000);
      idle();
      check("dm.mcs.state", {31'd0, u_dut.state_q}, 32'd0);
      expect_out("dm.mcs.nx", 1'b1, 4'b0000, 4'b0000, 4'b0000);

      // reset in MC with mc_cnt=10
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd11, 1'b0);
      idle();
      check("rmc.cnt", {27'd0, u_dut.mc_q}, 32'd10);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      expect_out("rmc.rst", 1'b0, 4'b0000, 4'b1111, 4'b0000);
      idle();
      check("rmc.state", {31'd0, u_dut.state_q}, 32'd0);
      expect_out("rmc.after", 1'b1, 4'b0000, 4'b0000, 4'b0000);
      check("rmc.perf_exe", bus.perf_exe, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
